// File: rtl/sw_debounce_pkg.sv
// Shared constants and helpers for the switch debouncer.
package sw_debounce_pkg;

  localparam int DEF_DEBOUNCE_CYCLES = 1000;
  localparam int DEF_REPEAT_DELAY    = 50000000;
  localparam int DEF_REPEAT_PERIOD   = 10000000;

  // Raw switches are active-low, so an idle switch reads 1.
  localparam logic RELEASED_LVL = 1'b1;
  localparam logic PRESSED_LVL  = ~RELEASED_LVL;

  function automatic int cnt_width(input int n);
    return $clog2(n) + 1;
  endfunction

endpackage

// File: rtl/sw_debounce_bit.sv
// One switch: 2-FF synchroniser, debounce counter, stable level and press/release pulses.
// Optional auto-repeat of the press pulse when SW_DEBOUNCE_REPEAT_EN is defined.
module sw_debounce_bit
  import sw_debounce_pkg::*;
#(
  parameter int P_DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int P_REPEAT_DELAY    = DEF_REPEAT_DELAY,
  parameter int P_REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
  input  logic clk,
  input  logic rst,
  input  logic sw_n,
  output logic level,
  output logic press_pulse,
  output logic release_pulse
);

  localparam int CNT_W = cnt_width(P_DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(P_DEBOUNCE_CYCLES - 1);

  if (P_DEBOUNCE_CYCLES < 1 || P_REPEAT_DELAY < 1 || P_REPEAT_PERIOD < 1) begin : g_param_chk
    $error("sw_debounce_bit: cycle parameters must be >= 1");
  end

  logic             sync_p0;
  logic             sync_p1;
  logic             stable;
  logic [CNT_W-1:0] cnt;
  logic             accept;
  logic             accept_press;
  logic             accept_release;
  logic             rpt_fire;

  assign accept         = (sync_p1 != stable) && (cnt == CNT_LAST);
  assign accept_press   = accept && (sync_p1 == PRESSED_LVL);
  assign accept_release = accept && (sync_p1 == RELEASED_LVL);
  assign level          = (stable == PRESSED_LVL);

  // Synchroniser stage, then debounce compare against the accepted level
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_p0       <= RELEASED_LVL;
      sync_p1       <= RELEASED_LVL;
      stable        <= RELEASED_LVL;
      cnt           <= '0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
    end else begin
      sync_p0       <= sw_n;
      sync_p1       <= sync_p0;
      press_pulse   <= accept_press | rpt_fire;
      release_pulse <= accept_release;
      if (sync_p1 == stable) begin
        cnt <= '0;
      end else if (accept) begin
        stable <= sync_p1;
        cnt    <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

`ifdef SW_DEBOUNCE_REPEAT_EN
  logic [31:0] rpt_cnt;
  logic        rpt_first;
  logic [31:0] rpt_last;

  // First repeat waits the long delay, later ones the shorter period.
  assign rpt_last = rpt_first ? 32'(P_REPEAT_DELAY - 1) : 32'(P_REPEAT_PERIOD - 1);
  assign rpt_fire = (stable == PRESSED_LVL) && !accept && (rpt_cnt == rpt_last);

  always_ff @(posedge clk) begin
    if (rst || stable == RELEASED_LVL || accept) begin
      rpt_cnt   <= '0;
      rpt_first <= 1'b1;
    end else if (rpt_fire) begin
      rpt_cnt   <= '0;
      rpt_first <= 1'b0;
    end else begin
      rpt_cnt <= rpt_cnt + 32'd1;
    end
  end
`else
  assign rpt_fire = 1'b0;
`endif

endmodule

// File: rtl/sw_debounce.sv
// Debounces an active-low switch bus into clean level plus press/release pulses.
// Define SW_DEBOUNCE_REPEAT_EN to enable press auto-repeat while a switch is held.
module sw_debounce
  import sw_debounce_pkg::*;
#(
  parameter int P_WIDTH           = 4,
  parameter int P_DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int P_REPEAT_DELAY    = DEF_REPEAT_DELAY,
  parameter int P_REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic [P_WIDTH-1:0] i_sw_n,
  output logic [P_WIDTH-1:0] o_sw_level,
  output logic [P_WIDTH-1:0] o_sw_press,
  output logic [P_WIDTH-1:0] o_sw_release
);

  for (genvar i = 0; i < P_WIDTH; i++) begin : g_bit
    sw_debounce_bit #(
      .P_DEBOUNCE_CYCLES(P_DEBOUNCE_CYCLES),
      .P_REPEAT_DELAY   (P_REPEAT_DELAY),
      .P_REPEAT_PERIOD  (P_REPEAT_PERIOD)
    ) u_bit (
      .clk          (i_clk),
      .rst          (i_rst),
      .sw_n         (i_sw_n[i]),
      .level        (o_sw_level[i]),
      .press_pulse  (o_sw_press[i]),
      .release_pulse(o_sw_release[i])
    );
  end

endmodule

// File: tb/tb_sw_debounce.sv
// Scoreboard bench for sw_debounce: a behavioural model predicts every cycle's outputs.
module tb_sw_debounce;

  localparam int W  = 4;
  localparam int DB = 4;
  localparam int RD = 10;
  localparam int RP = 5;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [W-1:0] sw_n = '1;
  logic [W-1:0] level, press, rls;

  int n_vec = 0;
  int n_err = 0;

  sw_debounce #(
    .P_WIDTH(W), .P_DEBOUNCE_CYCLES(DB), .P_REPEAT_DELAY(RD), .P_REPEAT_PERIOD(RP)
  ) dut (
    .i_clk(clk), .i_rst(rst), .i_sw_n(sw_n),
    .o_sw_level(level), .o_sw_press(press), .o_sw_release(rls)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
    end
  endtask

  // Model: a bit is accepted once its synchronised value has disagreed with the
  // accepted level on DB consecutive edges.
  logic [W-1:0]     m_s1 = '1, m_s2 = '1, m_stab = '1;
  int               run [W];
  int               held[W];
  logic [3*W-1:0]   exp_q[$];

  always @(posedge clk) begin
    logic [W-1:0] ep, er;
    ep = '0;
    er = '0;
    if (rst) begin
      m_s1 = '1; m_s2 = '1; m_stab = '1;
      for (int b = 0; b < W; b++) begin run[b] = 0; held[b] = 0; end
    end else begin
      for (int b = 0; b < W; b++) begin
        logic acc;
        acc = 1'b0;
        if (m_s2[b] !== m_stab[b]) begin
          run[b]++;
          if (run[b] == DB) begin
            acc       = 1'b1;
            run[b]    = 0;
            m_stab[b] = m_s2[b];
            if (m_s2[b] == 1'b0) ep[b] = 1'b1; else er[b] = 1'b1;
          end
        end else begin
          run[b] = 0;
        end
        if (acc) held[b] = 0;
        else if (m_stab[b] == 1'b0) begin
          held[b]++;
`ifdef SW_DEBOUNCE_REPEAT_EN
          if (held[b] == RD || (held[b] > RD && (held[b] - RD) % RP == 0)) ep[b] = 1'b1;
`endif
        end
      end
      m_s2 = m_s1;
      m_s1 = sw_n;
    end
    exp_q.push_back({~m_stab, ep, er});
  end

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      logic [3*W-1:0] e;
      e = exp_q.pop_front();
      check_eq("level",   32'(level), 32'(e[3*W-1:2*W]));
      check_eq("press",   32'(press), 32'(e[2*W-1:W]));
      check_eq("release", 32'(rls),   32'(e[W-1:0]));
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    logic [W-1:0] acc_out;
    int           presses;
    // Reset held with bit 0 pressed
    rst = 1'b1; sw_n = 4'b1110;
    cyc(3);
    rst = 1'b0;
    cyc(5);
    check_eq("rst_exit_nopulse", 32'(press), 32'h0);
    cyc(1);
    check_eq("rst_exit_press", 32'(press), 32'h1);
    cyc(1);
    check_eq("rst_exit_level", 32'(level), 32'h1);
    sw_n = 4'b1111;
    cyc(10);

    // Clean press and release on bit 1
    sw_n = 4'b1101;
    cyc(6);
    check_eq("clean_press", 32'(press), 32'h2);
    cyc(4);
    sw_n = 4'b1111;
    cyc(6);
    check_eq("clean_release", 32'(rls), 32'h2);
    cyc(4);

    // Bounce shorter than the debounce interval
    acc_out = '0;
    sw_n = 4'b1011; cyc(3);
    sw_n = 4'b1111; cyc(1);
    sw_n = 4'b1011; cyc(3);
    sw_n = 4'b1111;
    for (int i = 0; i < 10; i++) begin
      cyc(1);
      acc_out = acc_out | level | press | rls;
    end
    check_eq("bounce_quiet", 32'(acc_out), 32'h0);

    // Simultaneous press on bits 0 and 3
    sw_n = 4'b0110;
    cyc(6);
    check_eq("simul_press", 32'(press), 32'h9);
    check_eq("simul_level", 32'(level), 32'h9);
    cyc(4);
    sw_n = 4'b1111;
    cyc(10);

    // Reset in the middle of a debounce
    sw_n = 4'b0111;
    cyc(2);
    rst = 1'b1;
    cyc(2);
    check_eq("midrst_level", 32'(level), 32'h0);
    rst = 1'b0;
    cyc(5);
    check_eq("midrst_nopulse", 32'(press), 32'h0);
    cyc(1);
    check_eq("midrst_press", 32'(press), 32'h8);
    cyc(4);
    sw_n = 4'b1111;
    cyc(10);

    // Long hold on bit 0
    presses = 0;
    sw_n = 4'b1110;
    for (int i = 0; i < 40; i++) begin
      cyc(1);
      if (press[0]) presses++;
    end
    sw_n = 4'b1111;
    for (int i = 0; i < 20; i++) begin
      cyc(1);
      if (press[0]) presses++;
    end
`ifdef SW_DEBOUNCE_REPEAT_EN
    check_eq("hold_press_count", 32'(presses), 32'd7);
`else
    check_eq("hold_press_count", 32'(presses), 32'd1);
`endif
    check_eq("final_level", 32'(level), 32'h0);

    cyc(2);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
